// File: rtl/sram_line_ctrl.sv
`timescale 1ns/1ps
// sram_line_ctrl
// Moves one LINE_W-bit cache line to or from the DE2 16-bit asynchronous SRAM
// as LINE_W/16 consecutive halfword beats. Each beat is held for WAIT_CYC+1
// cycles so slower SRAM timing can be met without changing the cache side.
//
// Optional feature: define SRAM_CTRL_WMASK_EN to add a byte write mask port
// (i_WMASK) that drives the SRAM byte lanes on writes.
//
// Ports
//   clk_i, rst_ni     clock, synchronous active-low reset
//   i_ADDR            line base halfword address (low ADDR_W bits used)
//   i_WDATA           write line, beat b in [16b+15:16b]
//   i_WMASK           byte write mask (only with SRAM_CTRL_WMASK_EN)
//   i_WREN, i_RDEN    level requests; exactly one high starts a transfer
//   o_RDATA           read line, stable from o_ACK until the next read captures
//   o_ACK             one-cycle completion pulse
//   o_BUSY            transfer in progress
//   SRAM_*            SRAM pad interface
//
// State table
//   S_IDLE   | waiting for a request
//   S_ACCESS | beats in flight on the SRAM bus
//   S_ACK    | completion pulse; may accept the next request directly
module sram_line_ctrl #(
    parameter int LINE_W   = 128,
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [31:0]         i_ADDR,
    input  logic [LINE_W-1:0]   i_WDATA,
`ifdef SRAM_CTRL_WMASK_EN
    input  logic [LINE_W/8-1:0] i_WMASK,
`endif
    input  logic                i_WREN,
    input  logic                i_RDEN,
    output logic [LINE_W-1:0]   o_RDATA,
    output logic                o_ACK,
    output logic                o_BUSY,
    inout  wire  [15:0]         SRAM_DQ,
    output logic [ADDR_W-1:0]   SRAM_ADDR,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N,
    output logic                SRAM_LB_N,
    output logic                SRAM_UB_N
);

    localparam int NBEATS = LINE_W / 16;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [LINE_W-1:0]   rdata_q;
    logic                write_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [3:0]          wait_cnt_q;
`ifdef SRAM_CTRL_WMASK_EN
    logic [LINE_W/8-1:0] mask_q;
`endif

    logic                accept;
    logic                beat_end;
    logic                last_beat;
    logic                dq_en;
    logic [15:0]         dq_out;

    // Only the low ADDR_W bits address the SRAM; the rest are deliberately dropped.
    wire unused_addr = ^i_ADDR;

    assign accept    = (state_q != S_ACCESS) && (i_WREN ^ i_RDEN);
    // Wait timer counts down from WAIT_CYC; reaching zero marks the beat's last cycle.
    assign beat_end  = (wait_cnt_q == 4'd0);
    assign last_beat = (beat_q == BEAT_W'(NBEATS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ACK: state_d = accept ? S_ACCESS : S_IDLE;
            S_ACCESS:      if (beat_end && last_beat) state_d = S_ACK;
            default:       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            write_q    <= 1'b0;
            beat_q     <= '0;
            wait_cnt_q <= '0;
`ifdef SRAM_CTRL_WMASK_EN
            mask_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= i_ADDR[ADDR_W-1:0];
                wdata_q    <= i_WDATA;
                write_q    <= i_WREN;
                beat_q     <= '0;
                wait_cnt_q <= 4'(WAIT_CYC);
`ifdef SRAM_CTRL_WMASK_EN
                mask_q     <= i_WMASK;
`endif
            end else if (state_q == S_ACCESS) begin
                if (beat_end) begin
                    if (!write_q) begin
                        rdata_q[16*beat_q +: 16] <= SRAM_DQ;
                    end
                    // Wrap the beat index so it never points past the line.
                    beat_q     <= last_beat ? '0 : beat_q + 1'b1;
                    wait_cnt_q <= 4'(WAIT_CYC);
                end else begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                end
            end
        end
    end

    always_comb begin
        SRAM_ADDR = '0;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_LB_N = 1'b0;
        SRAM_UB_N = 1'b0;
        dq_en     = 1'b0;
        dq_out    = wdata_q[16*beat_q +: 16];
        if (state_q == S_ACCESS) begin
            SRAM_ADDR = addr_q + ADDR_W'(beat_q);
            SRAM_CE_N = 1'b0;
            if (write_q) begin
                dq_en = 1'b1;
`ifdef SRAM_CTRL_WMASK_EN
                SRAM_LB_N = ~mask_q[2*beat_q];
                SRAM_UB_N = ~mask_q[2*beat_q+1];
                // A fully masked beat keeps WE_N high but still spends its full time slot.
                SRAM_WE_N = ~(mask_q[2*beat_q] | mask_q[2*beat_q+1]);
`else
                SRAM_WE_N = 1'b0;
`endif
            end else begin
                SRAM_OE_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ = dq_en ? dq_out : 16'bz;
    assign o_RDATA = rdata_q;
    assign o_ACK   = (state_q == S_ACK);
    assign o_BUSY  = (state_q == S_ACCESS);

endmodule

// File: tb/tb_sram_line_ctrl.sv
`timescale 1ns/1ps
// Testbench for sram_line_ctrl. Two instances (WAIT_CYC=0 and WAIT_CYC=2),
// each attached to its own behavioural SRAM array. sel picks which instance
// receives requests and is observed; the other sees no requests.
module tb_sram_line_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel;
    logic         wren, rden;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  wmask;

    wire [127:0] rdata0, rdata1;
    wire         ack0, ack1, busy0, busy1;
    wire [15:0]  dq0, dq1;
    wire [17:0]  sa0, sa1;
    wire         ce0, oe0, we0, lb0, ub0;
    wire         ce1, oe1, we1, lb1, ub1;

    logic [15:0]  mem0 [0:262143];
    logic [15:0]  mem1 [0:262143];
    logic [127:0] last_rd [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_line_ctrl #(.LINE_W(128), .ADDR_W(18), .WAIT_CYC(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .i_ADDR(addr), .i_WDATA(wdata),
`ifdef SRAM_CTRL_WMASK_EN
        .i_WMASK(wmask),
`endif
        .i_WREN(wren & ~sel), .i_RDEN(rden & ~sel),
        .o_RDATA(rdata0), .o_ACK(ack0), .o_BUSY(busy0), .SRAM_DQ(dq0),
        .SRAM_ADDR(sa0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0), .SRAM_WE_N(we0),
        .SRAM_LB_N(lb0), .SRAM_UB_N(ub0)
    );

    sram_line_ctrl #(.LINE_W(128), .ADDR_W(18), .WAIT_CYC(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .i_ADDR(addr), .i_WDATA(wdata),
`ifdef SRAM_CTRL_WMASK_EN
        .i_WMASK(wmask),
`endif
        .i_WREN(wren & sel), .i_RDEN(rden & sel),
        .o_RDATA(rdata1), .o_ACK(ack1), .o_BUSY(busy1), .SRAM_DQ(dq1),
        .SRAM_ADDR(sa1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_WE_N(we1),
        .SRAM_LB_N(lb1), .SRAM_UB_N(ub1)
    );

    // Asynchronous SRAM models: drive data when read-enabled, store byte lanes on write.
    assign dq0 = (!ce0 && !oe0 && we0) ? mem0[sa0] : 16'hzzzz;
    assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce0 && !we0) begin
            if (!lb0) mem0[sa0][7:0]  <= dq0[7:0];
            if (!ub0) mem0[sa0][15:8] <= dq0[15:8];
        end
        if (!ce1 && !we1) begin
            if (!lb1) mem1[sa1][7:0]  <= dq1[7:0];
            if (!ub1) mem1[sa1][15:8] <= dq1[15:8];
        end
    end

    wire [127:0] rdata_v = sel ? rdata1 : rdata0;
    wire         ack_v   = sel ? ack1 : ack0;
    wire         busy_v  = sel ? busy1 : busy0;
    wire [17:0]  sa_v    = sel ? sa1 : sa0;
    wire [4:0]   ctl_v   = sel ? {ce1, oe1, we1, lb1, ub1} : {ce0, oe0, we0, lb0, ub0};

    function automatic logic [15:0] mem_rd(input logic s, input logic [17:0] a);
        return s ? mem1[a] : mem0[a];
    endfunction

    // Present a request so the next rising edge accepts it; optionally keep it asserted.
    task automatic start(input logic s, input logic wr, input logic [31:0] base,
                         input logic [127:0] wd, input logic hold);
        @(negedge clk);
        sel   = s;
        addr  = base;
        wdata = wd;
        wren  = wr;
        rden  = ~wr;
        @(posedge clk);
        #1;
        if (!hold) begin
            wren = 1'b0;
            rden = 1'b0;
        end
    endtask

    // Called just after the accepting edge. Checks every access cycle and the ACK cycle
    // against the beat schedule derived from base address, line length and wait count.
    task automatic check_xfer(input logic wr, input logic [31:0] base, input logic [127:0] wd,
                              input logic chain, input logic nwr, input logic [31:0] nbase,
                              input logic [127:0] nwd);
        int w, len, b;
        logic [127:0] snap;
        logic [15:0]  ew;
        logic [17:0]  ea;
        logic [6:0]   ev;
        w   = sel ? 2 : 0;
        len = 8 * (w + 1);
        for (int k = 0; k < 8; k++) snap[16*k +: 16] = mem_rd(sel, 18'(base[17:0] + 18'(k)));
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            b  = (c - 1) / (w + 1);
            ea = 18'(base[17:0] + 18'(b));
            if (wr) ev = {1'b0, 1'b1, ~(wmask[2*b] | wmask[2*b+1]), ~wmask[2*b], ~wmask[2*b+1], 1'b1, 1'b0};
            else    ev = 7'b0010010;
            n_checks++;
            if ({ctl_v, busy_v, ack_v} !== ev) begin
                n_fail++;
                $display("FAIL access_pins sel=%0d cycle=%0d: got %b expected %b", sel, c, {ctl_v, busy_v, ack_v}, ev);
            end
            n_checks++;
            if (sa_v !== ea) begin
                n_fail++;
                $display("FAIL sram_addr sel=%0d cycle=%0d: got %h expected %h", sel, c, sa_v, ea);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({ctl_v, busy_v, ack_v} !== 7'b1110001) begin
            n_fail++;
            $display("FAIL ack_cycle sel=%0d cycle=%0d: got %b expected %b", sel, len + 1, {ctl_v, busy_v, ack_v}, 7'b1110001);
        end
        if (!wr) last_rd[sel] = snap;
        n_checks++;
        if (rdata_v !== last_rd[sel]) begin
            n_fail++;
            $display("FAIL rdata sel=%0d: got %h expected %h", sel, rdata_v, last_rd[sel]);
        end
        if (wr) begin
            for (int k = 0; k < 8; k++) begin
                ew = snap[16*k +: 16];
                if (wmask[2*k])   ew[7:0]  = wd[16*k +: 8];
                if (wmask[2*k+1]) ew[15:8] = wd[16*k+8 +: 8];
                n_checks++;
                if (mem_rd(sel, 18'(base[17:0] + 18'(k))) !== ew) begin
                    n_fail++;
                    $display("FAIL mem_word sel=%0d word=%0d: got %h expected %h", sel, k, mem_rd(sel, 18'(base[17:0] + 18'(k))), ew);
                end
            end
        end
        if (chain) begin
            addr  = nbase;
            wdata = nwd;
            wren  = nwr;
            rden  = ~nwr;
        end else begin
            wren = 1'b0;
            rden = 1'b0;
        end
        @(posedge clk);
        #1;
        if (chain) begin
            wren = 1'b0;
            rden = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        n_checks++;
        if ({ctl_v[4], busy_v, ack_v} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s sel=%0d: got ce_n/busy/ack=%b expected 100", tag, sel, {ctl_v[4], busy_v, ack_v});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rdata0, ack0, busy0, sa0, ce0, oe0, we0, lb0, ub0} !== {128'd0, 2'b00, 18'd0, 5'b11100}) begin
            n_fail++;
            $display("FAIL reset_u0: got rdata=%h ack=%b busy=%b addr=%h ctl=%b", rdata0, ack0, busy0, sa0, {ce0, oe0, we0, lb0, ub0});
        end
        n_checks++;
        if ({rdata1, ack1, busy1, sa1, ce1, oe1, we1, lb1, ub1} !== {128'd0, 2'b00, 18'd0, 5'b11100}) begin
            n_fail++;
            $display("FAIL reset_u2: got rdata=%h ack=%b busy=%b addr=%h ctl=%b", rdata1, ack1, busy1, sa1, {ce1, oe1, we1, lb1, ub1});
        end
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        check_idle("idle_after_reset");
    endtask

    task automatic test_read_basic();
        for (int k = 0; k < 8; k++) mem0[18'h100 + 18'(k)] = 16'(k);
        start(1'b0, 1'b0, 32'h100, '0, 1'b0);
        check_xfer(1'b0, 32'h100, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (rdata0 !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin
            n_fail++;
            $display("FAIL read_line_held: got %h expected %h", rdata0, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        end
    endtask

    task automatic test_write_wrap();
        logic [15:0]  s_lo, s_hi;
        logic [127:0] d;
        d    = 128'h1111_2222_3333_4444_5555_6666_7777_8888 ^ {4{$urandom}};
        s_lo = mem1[18'h3FFFD];
        s_hi = mem1[18'h00006];
        start(1'b1, 1'b1, 32'h3FFFE, d, 1'b0);
        check_xfer(1'b1, 32'h3FFFE, d, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if ({mem1[18'h3FFFD], mem1[18'h00006]} !== {s_lo, s_hi}) begin
            n_fail++;
            $display("FAIL write_neighbours: got %h expected %h", {mem1[18'h3FFFD], mem1[18'h00006]}, {s_lo, s_hi});
        end
        check_idle("idle_after_write");
    endtask

    task automatic test_both_high();
        @(negedge clk);
        sel  = 1'b0;
        addr = 32'h40;
        wren = 1'b1;
        rden = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ce0, ack0, ce1, ack1} !== 4'b1010) begin
                n_fail++;
                $display("FAIL both_high cycle=%0d: got ce_n/ack u0=%b%b u2=%b%b expected 10 10", c, ce0, ack0, ce1, ack1);
            end
        end
        wren = 1'b0;
        rden = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        start(1'b0, 1'b0, 32'h2000, '0, 1'b1);
        check_xfer(1'b0, 32'h2000, '0, 1'b1, 1'b0, 32'h3FFFC, '0);
        check_xfer(1'b0, 32'h3FFFC, '0, 1'b0, 1'b0, '0, '0);
        check_idle("idle_after_b2b_read");
        start(1'b1, 1'b1, 32'h5000, d, 1'b1);
        check_xfer(1'b1, 32'h5000, d, 1'b1, 1'b0, 32'h5000, '0);
        check_xfer(1'b0, 32'h5000, '0, 1'b0, 1'b0, '0, '0);
        check_idle("idle_after_b2b_write_read");
    endtask

    task automatic test_random();
        logic         s, wr, ch, nwr;
        logic [31:0]  b, nb;
        logic [127:0] d, nd;
        for (int i = 0; i < 12; i++) begin
            s  = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            nwr = 1'($urandom_range(0, 1));
            b  = $urandom;
            nb = $urandom;
            d  = {$urandom, $urandom, $urandom, $urandom};
            nd = {$urandom, $urandom, $urandom, $urandom};
            start(s, wr, b, d, 1'b0);
            check_xfer(wr, b, d, ch, nwr, nb, nd);
            if (ch) check_xfer(nwr, nb, nd, 1'b0, 1'b0, '0, '0);
            check_idle("idle_after_random");
        end
    endtask

    task automatic test_reset_mid();
        start(1'b0, 1'b0, 32'h200, '0, 1'b0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        n_checks++;
        if ({ce0, busy0, ack0, rdata0} !== {3'b100, 128'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: got ce_n=%b busy=%b ack=%b rdata=%h expected 1 0 0 0", ce0, busy0, ack0, rdata0);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ce0, ack0} !== 2'b10) begin
                n_fail++;
                $display("FAIL reset_mid_no_ack cycle=%0d: got ce_n/ack=%b expected 10", c, {ce0, ack0});
            end
        end
    endtask

`ifdef SRAM_CTRL_WMASK_EN
    task automatic test_wmask();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        wmask = 16'h00F0;
        start(1'b0, 1'b1, 32'h7000, d, 1'b0);
        check_xfer(1'b1, 32'h7000, d, 1'b0, 1'b0, '0, '0);
        wmask = 16'h6A59;
        start(1'b1, 1'b1, 32'h7100, d, 1'b0);
        check_xfer(1'b1, 32'h7100, d, 1'b0, 1'b0, '0, '0);
        wmask = 16'hFFFF;
        check_idle("idle_after_wmask");
    endtask
`endif

    initial begin
        sel   = 1'b0;
        wren  = 1'b0;
        rden  = 1'b0;
        addr  = '0;
        wdata = '0;
        wmask = 16'hFFFF;
        rst_n = 1'b0;
        for (int a = 0; a < 262144; a++) begin
            mem0[a] = 16'(a * 7 + 3);
            mem1[a] = 16'(a * 13 + 5);
        end
        test_reset();
        test_read_basic();
        test_write_wrap();
        test_both_high();
        test_back_to_back();
        test_random();
`ifdef SRAM_CTRL_WMASK_EN
        test_wmask();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
